// File: rtl/rtlmem_1r1wnx_if.sv
// Port bundle for rtlmem_1r1wnx: clear handshake, write port and read port.
interface rtlmem_1r1wnx_if #(
  parameter int G_ADDR  = 10,
  parameter int G_WIDTH = 16
);
  logic               clren;
  logic               clrrdy;
  logic               memwe;
  logic [G_ADDR-1:0]  memwa;
  logic [G_WIDTH-1:0] memdi;
  logic               memre;
  logic [G_ADDR-1:0]  memra;
  logic [G_WIDTH-1:0] memdo;
  logic               memvld;

  modport master (
    output clren, memwe, memwa, memdi, memre, memra,
    input  clrrdy, memdo, memvld
  );

  modport slave (
    input  clren, memwe, memwa, memdi, memre, memra,
    output clrrdy, memdo, memvld
  );
endinterface

// File: rtl/rtlmem_1r1wnx.sv
// Simple-dual-port memory with clear sweep, write-first bypass and G_PIPELINE read latency.
// Optional macro RTLMEM_DBGZERO_EN zeroes memdo in every cycle without a valid result.
module rtlmem_1r1wnx #(
  parameter int                 G_ADDR     = 10,
  parameter int                 G_WIDTH    = 16,
  parameter int                 G_DEPTH    = 2**G_ADDR,
  parameter int                 G_PIPELINE = 2,
  parameter logic [G_WIDTH-1:0] G_RST_VAL  = {G_WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             rst_n,
  rtlmem_1r1wnx_if.slave  bus
);

  localparam logic [0:0]        ST_CLR    = 1'b0;
  localparam logic [0:0]        ST_IDLE   = 1'b1;
  localparam logic [G_ADDR:0]   DEPTH_W   = (G_ADDR+1)'(G_DEPTH);
  localparam logic [G_ADDR-1:0] LAST_ADDR = G_ADDR'(G_DEPTH - 1);
`ifdef RTLMEM_DBGZERO_EN
  localparam logic [G_WIDTH-1:0] DO_RST   = {G_WIDTH{1'b0}};
`else
  localparam logic [G_WIDTH-1:0] DO_RST   = G_RST_VAL;
`endif

  function automatic logic in_range(input logic [G_ADDR-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];

  logic [0:0]                            state_q, state_d;
  logic [G_ADDR-1:0]                     cnt_q, cnt_d;
  logic                                  clrrdy_q, clrrdy_d;
  logic [G_PIPELINE-1:0]                 vld_q, vld_d;
  logic [G_PIPELINE-1:0][G_WIDTH-1:0]    dat_q, dat_d;
  logic                                  memvld_q, memvld_d;
  logic [G_WIDTH-1:0]                    memdo_q, memdo_d;

  logic                                  wr_acc_s;
  logic                                  rd_ok_s;
  logic [G_WIDTH-1:0]                    rd_data_s;
  logic                                  mem_we_s;
  logic [G_ADDR-1:0]                     mem_wa_s;
  logic [G_WIDTH-1:0]                    mem_wd_s;

  // Clear sweep FSM: one address per edge, leaves on the edge writing the last word
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clrrdy_d = clrrdy_q;
    case (state_q)
      ST_CLR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d  = ST_IDLE;
          clrrdy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.clren) begin
          state_d  = ST_CLR;
          cnt_d    = {G_ADDR{1'b0}};
          clrrdy_d = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_CLR;
        cnt_d    = {G_ADDR{1'b0}};
        clrrdy_d = 1'b0;
      end
    endcase
  end

  // Array write port is shared between the sweep and user writes
  always_comb begin
    wr_acc_s = (state_q == ST_IDLE) & bus.memwe & in_range(bus.memwa);
    if (state_q == ST_CLR) begin
      mem_we_s = 1'b1;
      mem_wa_s = cnt_q;
      mem_wd_s = G_RST_VAL;
    end else begin
      mem_we_s = wr_acc_s;
      mem_wa_s = bus.memwa;
      mem_wd_s = bus.memdi;
    end
  end

  // Reads during a sweep, on the clear-accept edge, or out of range yield the fill value
  always_comb begin
    rd_ok_s = (state_q == ST_IDLE) & ~bus.clren & in_range(bus.memra);
    if (!rd_ok_s) begin
      rd_data_s = G_RST_VAL;
    end else if (wr_acc_s && (bus.memwa == bus.memra)) begin
      rd_data_s = bus.memdi;
    end else begin
      rd_data_s = mem_q[bus.memra];
    end
  end

  always_comb begin
    vld_d[0] = bus.memre;
    dat_d[0] = rd_data_s;
    for (int i = 1; i < G_PIPELINE; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    memvld_d = vld_q[G_PIPELINE-1];
    if (vld_q[G_PIPELINE-1]) begin
      memdo_d = dat_q[G_PIPELINE-1];
    end else begin
`ifdef RTLMEM_DBGZERO_EN
      memdo_d = {G_WIDTH{1'b0}};
`else
      memdo_d = memdo_q;
`endif
    end
  end

  // Storage itself has no reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_wa_s] <= mem_wd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLR;
      cnt_q    <= {G_ADDR{1'b0}};
      clrrdy_q <= 1'b0;
      vld_q    <= {G_PIPELINE{1'b0}};
      dat_q    <= {(G_PIPELINE*G_WIDTH){1'b0}};
      memvld_q <= 1'b0;
      memdo_q  <= DO_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clrrdy_q <= clrrdy_d;
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      memvld_q <= memvld_d;
      memdo_q  <= memdo_d;
    end
  end

  assign bus.clrrdy = clrrdy_q;
  assign bus.memvld = memvld_q;
  assign bus.memdo  = memdo_q;

endmodule

// File: doc/rtlmem_1r1wnx.md
Name: rtlmem_1r1wnx

Overview:
Single-clock simple-dual-port memory: one write port and one read port, with read latency set by a parameter (1..4 cycles).
- Successor to the fixed-latency 1R1W wrappers. Adds a built-in clear engine, a read-valid strobe, write-first collision semantics and out-of-range address protection.
- Storage is an inferred array, so the block needs no vendor primitive.
- Sits behind packet or lookup engines that need a cleared table after reset and a known read latency.

Parameters:
G_ADDR, 10, address width
G_WIDTH, 16, data width
G_DEPTH, 2**G_ADDR, number of words; legal range 2..2**G_ADDR
G_PIPELINE, 2, read latency in clk cycles; legal range 1..4
G_RST_VAL, {G_WIDTH{1'b0}}, clear-fill value and reset value of memdo

Ports:
clk     in   1        sole clock; all logic on rising edge
rst_n   in   1        asynchronous active-low reset
clren   in   1        request a full clear; sampled only while clrrdy=1
clrrdy  out  1        1 = clear complete, user writes accepted
memwe   in   1        write enable
memwa   in   G_ADDR   write address
memdi   in   G_WIDTH  write data
memre   in   1        read enable
memra   in   G_ADDR   read address
memdo   out  G_WIDTH  read data
memvld  out  1        memdo carries the result of a read issued G_PIPELINE cycles earlier

Behaviour:
Reset (rst_n=0, asynchronous):
- clrrdy=0, memvld=0, memdo=G_RST_VAL.
- Read-valid pipeline is cleared; clear counter is set to 0; FSM goes to CLR.
- Array contents are not reset directly; the clear sweep initialises them.

Clear FSM, two states:
- CLR: each clk edge writes G_RST_VAL to the address in the counter, then increments the counter.
- CLR -> IDLE on the edge that writes address G_DEPTH-1. clrrdy=1 from that edge on. A sweep therefore takes exactly G_DEPTH edges.
- IDLE: clren=1 sampled on an edge -> counter=0, clrrdy=0, state CLR.
- clren is ignored while in CLR; the sweep is not restarted.
- rst_n asserted mid-sweep -> sweep restarts from address 0 after release.

Writes:
- Accepted only when clrrdy=1 and memwe=1 and memwa<G_DEPTH.
- Writes during CLR, or with memwa>=G_DEPTH, are dropped silently.

Reads:
- memre=1 on edge N captures memra.
- memvld=1 and memdo=result on edge N+G_PIPELINE, for exactly one cycle per read.
- Back-to-back reads give back-to-back results, throughput 1 per cycle, order preserved.

Read result:
- memra>=G_DEPTH returns G_RST_VAL.
- A read issued during CLR, or on the edge where clren is accepted, returns G_RST_VAL.
- Otherwise the result reflects all writes accepted on edges <= N. A write to the same address on edge N is visible (write-first). Writes after edge N are not visible.

Idle output:
- When memvld=0, memdo holds its last value; see Optional Feature.

Collision table:
- Write and read to the same address on the same edge return memdi.
- Write and read to different addresses are independent.

Optional Feature:
Macro RTLMEM_DBGZERO_EN.
- Defined: memdo is forced to {G_WIDTH{1'b0}} in every cycle where memvld=0, to ease waveform debug. Valid cycles are unchanged.
- Not defined: memdo holds the last read result (G_RST_VAL after reset); no extra gating logic.

Test Plan:
All scenarios use G_ADDR=4, G_DEPTH=12, G_WIDTH=8, G_PIPELINE=3, G_RST_VAL=8'hA5.
1. Release rst_n. clrrdy rises on the 12th edge. Then read addresses 0..11 back-to-back -> memvld high for 12 consecutive cycles starting 3 edges after the first read, memdo=8'hA5 each.
2. Write 0x3C to address 5 on edge N, read address 5 on edge N (collision) -> memdo=0x3C, memvld=1 at edge N+3.
3. Read address 5 on edge N, then write 0x77 to address 5 on edge N+1 -> memdo=0x3C at N+3. A read on N+2 returns 0x77 at N+5.
4. Write 0x11 to address 13 (out of range), then read address 13 -> memdo=0xA5. Contents of addresses 1 and 13 mod 12 are unchanged.
5. Pulse clren with clrrdy=1. Write 0x99 to address 2 during the sweep (dropped); read during the sweep -> 0xA5. clrrdy returns high after 12 edges; address 2 reads 0xA5.
6. Assert rst_n at sweep address 6, then release -> clrrdy stays low for a full 12 edges, and memvld=0 during reset. With RTLMEM_DBGZERO_EN defined, memdo=0x00 in every idle cycle.
